// File: rtl/ysyx_23060077_riscv_axi_master.sv
// AXI4-Lite initiator bridge: turns one core memory request at a time into
// AR/R or AW/W/B handshakes and returns a single-cycle completion pulse.
module ysyx_23060077_riscv_axi_master #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          STRB_W   = 4,
    parameter int          RESP_W   = 2,
    parameter int          PORT_W   = 3,
    parameter logic [2:0]  PROT_VAL = 3'b000
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              axi_aw_valid_o,
    input  logic              axi_aw_ready_i,
    output logic [ADDR_W-1:0] axi_aw_addr_o,
    output logic [PORT_W-1:0] axi_aw_port_o,
    output logic              axi_w_valid_o,
    input  logic              axi_w_ready_i,
    output logic [DATA_W-1:0] axi_w_data_o,
    output logic [STRB_W-1:0] axi_w_strb_o,
    input  logic              axi_b_valid_i,
    output logic              axi_b_ready_o,
    input  logic [RESP_W-1:0] axi_b_resp_i,
    output logic              axi_ar_valid_o,
    input  logic              axi_ar_ready_i,
    output logic [ADDR_W-1:0] axi_ar_addr_o,
    output logic [PORT_W-1:0] axi_ar_port_o,
    input  logic              axi_r_valid_i,
    output logic              axi_r_ready_o,
    input  logic [RESP_W-1:0] axi_r_resp_i,
    input  logic [DATA_W-1:0] axi_r_data_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t              state_r,      state_s;
    logic                aw_valid_r,   aw_valid_s;
    logic                w_valid_r,    w_valid_s;
    logic                ar_valid_r,   ar_valid_s;
    logic                r_ready_r,    r_ready_s;
    logic                b_ready_r,    b_ready_s;
    logic                aw_done_r,    aw_done_s;
    logic                w_done_r,     w_done_s;
    logic                resp_valid_r, resp_valid_s;
    logic                resp_err_r,   resp_err_s;
    logic [ADDR_W-1:0]   addr_r,       addr_s;
    logic [DATA_W-1:0]   wdata_r,      wdata_s;
    logic [STRB_W-1:0]   wstrb_r,      wstrb_s;
    logic [DATA_W-1:0]   rdata_r,      rdata_s;

    // State and registered-output update with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_r      <= IDLE;
            aw_valid_r   <= 1'b0;
            w_valid_r    <= 1'b0;
            ar_valid_r   <= 1'b0;
            r_ready_r    <= 1'b0;
            b_ready_r    <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            wstrb_r      <= {STRB_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            aw_valid_r   <= aw_valid_s;
            w_valid_r    <= w_valid_s;
            ar_valid_r   <= ar_valid_s;
            r_ready_r    <= r_ready_s;
            b_ready_r    <= b_ready_s;
            aw_done_r    <= aw_done_s;
            w_done_r     <= w_done_s;
            resp_valid_r <= resp_valid_s;
            resp_err_r   <= resp_err_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            wstrb_r      <= wstrb_s;
            rdata_r      <= rdata_s;
        end
    end

    // Next-state and next registered-output computation
    always_comb begin
        state_s      = state_r;
        aw_valid_s   = aw_valid_r;
        w_valid_s    = w_valid_r;
        ar_valid_s   = ar_valid_r;
        r_ready_s    = r_ready_r;
        b_ready_s    = b_ready_r;
        aw_done_s    = aw_done_r;
        w_done_s     = w_done_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        wstrb_s      = wstrb_r;
        rdata_s      = rdata_r;
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    addr_s  = req_addr;
                    wdata_s = req_wdata;
                    wstrb_s = req_wstrb;
                    if (req_wen) begin
                        state_s    = WR_REQ;
                        aw_valid_s = 1'b1;
                        w_valid_s  = 1'b1;
                        aw_done_s  = 1'b0;
                        w_done_s   = 1'b0;
                    end else begin
                        state_s    = RD_ADDR;
                        ar_valid_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (axi_ar_ready_i) begin
                    ar_valid_s = 1'b0;
                    r_ready_s  = 1'b1;
                    state_s    = RD_DATA;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (axi_r_valid_i) begin
                    rdata_s      = axi_r_data_i;
                    resp_err_s   = (axi_r_resp_i != {RESP_W{1'b0}});
                    resp_valid_s = 1'b1;
                    r_ready_s    = 1'b0;
                    state_s      = IDLE;
                end else begin
                    state_s = RD_DATA;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once both are done
                if (aw_valid_r && axi_aw_ready_i) begin
                    aw_valid_s = 1'b0;
                    aw_done_s  = 1'b1;
                end else begin
                    aw_done_s = aw_done_r;
                end
                if (w_valid_r && axi_w_ready_i) begin
                    w_valid_s = 1'b0;
                    w_done_s  = 1'b1;
                end else begin
                    w_done_s = w_done_r;
                end
                if (aw_done_s && w_done_s) begin
                    b_ready_s = 1'b1;
                    state_s   = WR_RESP;
                end else begin
                    state_s = WR_REQ;
                end
            end
            WR_RESP: begin
                if (axi_b_valid_i) begin
                    resp_err_s   = (axi_b_resp_i != {RESP_W{1'b0}});
                    resp_valid_s = 1'b1;
                    b_ready_s    = 1'b0;
                    state_s      = IDLE;
                end else begin
                    state_s = WR_RESP;
                end
            end
            default: begin
                state_s    = IDLE;
                aw_valid_s = 1'b0;
                w_valid_s  = 1'b0;
                ar_valid_s = 1'b0;
                r_ready_s  = 1'b0;
                b_ready_s  = 1'b0;
            end
        endcase
    end

    assign req_ready      = (state_r == IDLE);
    assign resp_valid     = resp_valid_r;
    assign resp_err       = resp_err_r;
    assign resp_rdata     = rdata_r;
    assign axi_aw_valid_o = aw_valid_r;
    assign axi_aw_addr_o  = addr_r;
    assign axi_aw_port_o  = PROT_VAL;
    assign axi_w_valid_o  = w_valid_r;
    assign axi_w_data_o   = wdata_r;
    assign axi_w_strb_o   = wstrb_r;
    assign axi_b_ready_o  = b_ready_r;
    assign axi_ar_valid_o = ar_valid_r;
    assign axi_ar_addr_o  = addr_r;
    assign axi_ar_port_o  = PROT_VAL;
    assign axi_r_ready_o  = r_ready_r;

endmodule

// File: doc/ysyx_23060077_riscv_axi_master.md
Name: ysyx_23060077_riscv_axi_master

Overview:
- AXI4-Lite initiator bridge between the core's simple memory request port (IFU/LSU side) and the AXI fabric, e.g. the AXI SRAM responder.
- Accepts one read or write request at a time and drives the matching AR/R or AW/W/B channel handshakes.
- Returns read data and response status to the core as a one-cycle response pulse.
- Single transaction outstanding; no bursts, no IDs.

Parameters:
- ADDR_W, 32, address width (matches AXI_ADDR_WIDTH)
- DATA_W, 32, data width (matches AXI_DATA_WIDTH)
- STRB_W, 4, write strobe width, DATA_W/8
- RESP_W, 2, AXI response width
- PORT_W, 3, AXI protection ("port") field width
- PROT_VAL, 3'b000, constant driven on aw_port/ar_port

Ports:
- aclk  in  1  clock, rising edge
- areset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_wen  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address, forwarded unchanged
- req_wdata  in  DATA_W  write data
- req_wstrb  in  STRB_W  write byte strobes
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  read data (valid with resp_valid on reads)
- resp_err  out  1  AXI resp != OKAY (2'b00)
- axi_aw_valid_o  out  1; axi_aw_ready_i  in  1; axi_aw_addr_o  out  ADDR_W; axi_aw_port_o  out  PORT_W
- axi_w_valid_o  out  1; axi_w_ready_i  in  1; axi_w_data_o  out  DATA_W; axi_w_strb_o  out  STRB_W
- axi_b_valid_i  in  1; axi_b_ready_o  out  1; axi_b_resp_i  in  RESP_W
- axi_ar_valid_o  out  1; axi_ar_ready_i  in  1; axi_ar_addr_o  out  ADDR_W; axi_ar_port_o  out  PORT_W
- axi_r_valid_i  in  1; axi_r_ready_o  out  1; axi_r_resp_i  in  RESP_W; axi_r_data_i  in  DATA_W

Behaviour:
- One clock (aclk); reset synchronous, active-low (areset_n sampled on rising edge).
- Reset values:
  - state=IDLE
  - all *_valid_o, *_ready_o, resp_valid and resp_err = 0
  - addr/data/strb/rdata registers = 0
  - req_ready=1 after reset release
- req_ready = (state==IDLE). A request is accepted on a cycle with req_valid && req_ready; addr, wdata, wstrb and wen are latched.
- States:
  - IDLE: on read accept -> RD_ADDR with ar_valid=1 next cycle. On write accept -> WR_REQ with aw_valid=1 and w_valid=1 next cycle; aw_done and w_done cleared.
  - RD_ADDR: ar_valid held with stable addr until ar_ready. On the handshake edge: ar_valid->0, r_ready->1, go to RD_DATA.
  - RD_DATA: r_ready=1. On r_valid: capture r_data into resp_rdata, err=(r_resp!=0), r_ready->0, resp_valid=1 next cycle, go to IDLE.
  - WR_REQ: AW and W are independent.
    - aw_valid drops the edge after aw_ready and sets aw_done; w_valid drops the edge after w_ready and sets w_done.
    - Both ready in the same cycle: both handshakes complete.
    - Once both are done (including in the same cycle): b_ready->1, go to WR_RESP.
    - Payload stays stable while the corresponding valid is high.
  - WR_RESP: b_ready=1. On b_valid: err=(b_resp!=0), b_ready->0, resp_valid=1 next cycle, go to IDLE.
- Valid is never withdrawn before its handshake, and valid never depends combinationally on ready.
- Response timing:
  - resp_valid is exactly one cycle and coincides with the first IDLE cycle.
  - A new request may be accepted in that same cycle.
  - resp_rdata holds its value until the next read completes.
  - resp_err is valid only with resp_valid.
- Latency with zero-wait slave:
  - read: accept T, ar_valid T+1, r_ready T+2, r_valid sampled T+2, resp_valid T+3
  - write: accept T, aw/w_valid T+1, b_ready T+2, resp_valid T+3
- A b_valid that arrives before b_ready is asserted is held by the slave; the bridge samples it on entry to WR_RESP.
- The slave may raise b_valid/r_valid only after seeing ready; the bridge must not require b_valid/r_valid before asserting ready.
- wstrb=0: a write is still issued.
- Reset mid-transaction: the next edge forces IDLE and drops all valids/readies; the transaction is abandoned with no resp_valid.
- Port signals are constant PROT_VAL.

Test Plan:
- Read, zero-wait slave returning 32'hDEADBEEF at 0x8000_0004 -> ar_addr=0x80000004 at T+1, resp_valid at T+3, resp_rdata=0xDEADBEEF, resp_err=0.
- Write 0x8000_0010 data 0x12345678 strb 4'b0011, aw_ready 3 cycles before w_ready -> aw_valid drops after its handshake, w_valid held until its own handshake, one b handshake, single resp_valid pulse.
- Slave asserts b_valid only after seeing b_ready (SRAM responder style), and r_valid two cycles after r_ready -> both complete, no deadlock, exactly one resp_valid each.
- r_resp=2'b10 on a read -> resp_err=1 with resp_valid. b_resp=2'b11 on a write -> resp_err=1.
- Back-to-back: new request presented in the resp_valid cycle -> accepted that cycle, ar_valid/aw_valid the next cycle.
- areset_n=0 for one cycle while in WR_REQ with aw_valid=1 -> next cycle all valids 0, req_ready=1, no resp_valid.
